// File: rtl/ms_stopwatch.sv
// Millisecond stopwatch: counts 1 ms ticks under start/stop/clear control and
// presents the count both as binary and as four BCD digits (s.mmm).
module ms_stopwatch #(
  parameter int unsigned MAX_MS = 9999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_1ms,
  input  logic        start_stop,
  input  logic        clear,
  output logic        running,
  output logic        overflow,
  output logic [13:0] elapsed_ms,
  output logic [3:0]  sec_ones,
  output logic [3:0]  ms_hund,
  output logic [3:0]  ms_tens,
  output logic [3:0]  ms_ones
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_STOPPED,
    S_OVERFLOW
  } state_t;

  localparam logic [13:0] MAX_VAL = 14'(MAX_MS);

  state_t      r_state;
  logic [13:0] r_elapsed;
  logic [3:0]  r_digit [4];
  logic        r_running;
  logic        r_overflow;

  logic [3:0]  w_digit_inc [4];
  logic [3:0]  w_carry;
  logic        w_at_max;

  assign w_carry[0] = 1'b1;
  assign w_at_max   = (r_elapsed == MAX_VAL);

  // BCD ripple increment: digit 0 is ms_ones, digit 3 is sec_ones.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
      assign w_digit_inc[gi] = !w_carry[gi]          ? r_digit[gi] :
                               (r_digit[gi] == 4'd9) ? 4'd0 :
                                                       r_digit[gi] + 4'd1;
      if (gi < 3) begin : g_carry
        assign w_carry[gi+1] = w_carry[gi] && (r_digit[gi] == 4'd9);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_elapsed  <= '0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < 4; i++) r_digit[i] <= '0;
    end else if (clear) begin
      r_state    <= S_IDLE;
      r_elapsed  <= '0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < 4; i++) r_digit[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_stop) begin
            r_state   <= S_RUNNING;
            r_running <= 1'b1;
          end
        end
        S_RUNNING: begin
          // A tick at the ceiling beats a simultaneous start_stop.
          if (tick_1ms && w_at_max) begin
            r_state    <= S_OVERFLOW;
            r_running  <= 1'b0;
            r_overflow <= 1'b1;
          end else begin
            if (tick_1ms) begin
              r_elapsed <= r_elapsed + 14'd1;
              for (int i = 0; i < 4; i++) r_digit[i] <= w_digit_inc[i];
            end
            if (start_stop) begin
              r_state   <= S_STOPPED;
              r_running <= 1'b0;
            end
          end
        end
        S_STOPPED: begin
          if (start_stop) begin
            r_state   <= S_RUNNING;
            r_running <= 1'b1;
          end
        end
        S_OVERFLOW: begin
          r_state <= S_OVERFLOW;
        end
        default: begin
          r_state    <= S_IDLE;
          r_running  <= 1'b0;
          r_overflow <= 1'b0;
        end
      endcase
    end
  end

  assign running    = r_running;
  assign overflow   = r_overflow;
  assign elapsed_ms = r_elapsed;
  assign ms_ones    = r_digit[0];
  assign ms_tens    = r_digit[1];
  assign ms_hund    = r_digit[2];
  assign sec_ones   = r_digit[3];

endmodule

// File: doc/ms_stopwatch.md
# ms_stopwatch

Millisecond stopwatch that consumes the 1 ms tick produced by the system clock divider. It counts elapsed time under start/stop/clear control and presents the count as four BCD digits (s.mmm) for the seven-segment display driver, plus a parallel binary count. It sits directly downstream of the 1 ms clock divider and upstream of the display multiplexer.

## Interface

- MAX_MS, 9999: saturation value in milliseconds; legal range 1..9999.
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  asynchronous active-low reset.
- tick_1ms  input  1  single-cycle pulse, once per millisecond, synchronous to clk.
- start_stop  input  1  single-cycle command pulse (already debounced and edge-detected); toggles run/stop.
- clear  input  1  single-cycle command pulse; returns to zero and IDLE.
- running  output  1  high in RUNNING state.
- overflow  output  1  high in OVERFLOW state.
- elapsed_ms  output  14  binary elapsed milliseconds.
- sec_ones  output  4  BCD seconds digit.
- ms_hund  output  4  BCD hundreds-of-ms digit.
- ms_tens  output  4  BCD tens-of-ms digit.
- ms_ones  output  4  BCD ones-of-ms digit.

## Operation

- Reset (reset_n low, asynchronous): state IDLE; all digits 0, elapsed_ms 0, running 0, overflow 0.
- States: IDLE, RUNNING, STOPPED, OVERFLOW.
- IDLE: counts held at 0. start_stop goes to RUNNING. tick_1ms ignored.
- RUNNING: on each tick_1ms, elapsed_ms increments by 1 and the BCD digits increment with ripple carry (ms_ones 9->0 carries into ms_tens, and so on up to sec_ones). start_stop goes to STOPPED and the counts freeze.
- STOPPED: counts held. start_stop returns to RUNNING and resumes from the held value. tick_1ms ignored.
- OVERFLOW: entered from RUNNING when a tick arrives with elapsed_ms == MAX_MS. The count does not increment and stays at MAX_MS. start_stop is ignored; only clear exits.
- clear: highest priority in every state. Next cycle: state IDLE, all counts 0, overflow 0.
- Simultaneous events in RUNNING:
  - tick_1ms and start_stop together: the increment is applied and the state becomes STOPPED, so the frozen value includes that tick.
  - tick_1ms at MAX_MS and start_stop together: the state becomes OVERFLOW (overflow wins).
- Simultaneous clear with anything: clear wins. No increment; state IDLE.
- Width and arithmetic rules:
  - The BCD digits are each 0..9 and are never allowed to hold an illegal code.
  - elapsed_ms always equals sec_ones*1000 + ms_hund*100 + ms_tens*10 + ms_ones.
  - elapsed_ms is held in 14 bits; the maximum value is 9999.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: a tick or command sampled at rising edge N is visible on the outputs after edge N (one-cycle registered update).
- running and overflow change on the same edge as the state.
- Command pulses are single-cycle. A start_stop held high for k cycles toggles the state k times; no level handling is provided.
- tick_1ms is assumed to be at least 2 cycles apart. Back-to-back ticks must still increment once per tick-cycle.
- reset_n asserted mid-count clears everything immediately, without waiting for clk. Deassertion is synchronous to clk at the system level.

## Test plan

- Reset then count: release reset_n, pulse start_stop, apply 1234 ticks -> digits 1,2,3,4; elapsed_ms 1234; running 1.
- Carry chain: run to 999, apply one tick -> digits 1,0,0,0 on the next cycle; elapsed_ms 1000.
- Stop/resume: at 0.500 pulse start_stop, apply 20 ticks -> count stays 500 and running 0. Pulse start_stop again, apply 5 ticks -> 505.
- Simultaneous tick and start_stop at 41 -> stops at 42.
- Overflow: MAX_MS=9999, run 10005 ticks -> holds 9,9,9,9, overflow 1, running 0. A start_stop pulse causes no change. clear -> all 0, IDLE.
- Async reset: assert reset_n between clk edges while at 3.210 -> outputs 0 before the next edge. Clear in the same cycle as a tick at 77 -> elapsed_ms 0.
